rps_match: RTL

RPS_MATCH -- requirements
Module: rps_match

---
 rtl/rps_pkg.sv | 26 ++
 rtl/rps_lfsr.sv | 21 ++
 rtl/rps_match.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/rps_pkg.sv
// Shared types for the rock-paper-scissors match: FSM state and round-result encodings,
// LFSR feedback taps and fixed LED patterns.
package rps_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHOOSE = 3'd1,
        ST_REVEAL = 3'd2,
        ST_SCORE  = 3'd3,
        ST_OVER   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_WIN  = 2'd1,
        RES_LOSE = 2'd2,
        RES_TIE  = 2'd3
    } result_e;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS  = 8'b1011_1000;

    localparam logic [9:0] LED_IDLE   = 10'b1000000000;
    localparam logic [9:0] LED_CHOOSE = 10'b1011111101;

endpackage

// File: rtl/rps_lfsr.sv
// Free-running 8-bit maximal-length LFSR used as the CPU's random hand source.
// Advances every cycle; reset loads SEED (must be nonzero).
module rps_lfsr
    import rps_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else begin
            value <= {value[6:0], ^(value & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/rps_match.sv
// Rock-paper-scissors (generalised to NUM_CHOICES hands) match controller with pushbutton input.
// Optional macro RPS_LED_SCROLL_EN: rotating one-hot LED on a player win instead of all-on.
module rps_match
    import rps_pkg::*;
#(
    parameter int         NUM_CHOICES  = 3,
    parameter int         WIN_TARGET   = 3,
    parameter int         SCORE_W      = 4,
    parameter logic [7:0] LFSR_SEED    = 8'hA5,
    parameter int         SCROLL_DIV_W = 22,
    localparam int        CW           = $clog2(NUM_CHOICES)
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               start,
    input  logic               incbutton,
    input  logic               selectbutton,
    input  logic               clear_scores,
    input  logic               cpu_force_en,
    input  logic [CW-1:0]      cpu_force,
    output logic [CW-1:0]      player_choice,
    output logic [CW-1:0]      cpu_choice,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] cpu_score,
    output logic [1:0]         result,
    output logic [2:0]         state,
    output logic               match_over,
    output logic [9:0]         led
);

    localparam logic [CW-1:0]      MAX_CHOICE = CW'(NUM_CHOICES - 1);
    localparam logic [CW:0]        NC_EXT     = (CW+1)'(NUM_CHOICES);
    localparam logic [SCORE_W-1:0] TARGET     = SCORE_W'(WIN_TARGET);

    state_e             st;
    result_e            res;
    result_e            rev_res;
    logic               player_won;
    logic [7:0]         lfsr_val;
    logic [CW-1:0]      lfsr_pick;
    logic [CW:0]        diff;
    logic [SCORE_W-1:0] p_inc;
    logic [SCORE_W-1:0] c_inc;
    logic [9:0]         over_led;

    logic inc_s1, inc_s2, inc_s3;
    logic sel_s1, sel_s2, sel_s3;
    logic inc_press, sel_press;

    rps_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (Clock),
        .rst_n (Resetn),
        .value (lfsr_val)
    );

    // Two synchroniser flops plus one history flop for rising-edge detection
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            {inc_s1, inc_s2, inc_s3} <= 3'b000;
            {sel_s1, sel_s2, sel_s3} <= 3'b000;
        end else begin
            {inc_s1, inc_s2, inc_s3} <= {incbutton, inc_s1, inc_s2};
            {sel_s1, sel_s2, sel_s3} <= {selectbutton, sel_s1, sel_s2};
        end
    end

    assign inc_press = inc_s2 & ~inc_s3;
    assign sel_press = sel_s2 & ~sel_s3;
    assign lfsr_pick = CW'(lfsr_val % 8'(NUM_CHOICES));

    always_comb begin
        if (player_choice >= cpu_choice) begin
            diff = {1'b0, player_choice} - {1'b0, cpu_choice};
        end else begin
            diff = {1'b0, player_choice} + NC_EXT - {1'b0, cpu_choice};
        end
        if (diff == '0) begin
            rev_res = RES_TIE;
        end else if (diff[0]) begin
            rev_res = RES_WIN;
        end else begin
            rev_res = RES_LOSE;
        end
    end

    assign p_inc = (&player_score) ? player_score : player_score + SCORE_W'(1);
    assign c_inc = (&cpu_score)    ? cpu_score    : cpu_score    + SCORE_W'(1);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            st            <= ST_IDLE;
            res           <= RES_NONE;
            player_won    <= 1'b0;
            player_choice <= '0;
            cpu_choice    <= '0;
            player_score  <= '0;
            cpu_score     <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        st            <= ST_CHOOSE;
                        player_choice <= '0;
                        res           <= RES_NONE;
                        player_won    <= 1'b0;
                    end
                end
                ST_CHOOSE: begin
                    // A select press takes priority over a simultaneous increment
                    if (sel_press) begin
                        cpu_choice <= cpu_force_en ? cpu_force : lfsr_pick;
                        st         <= ST_REVEAL;
                    end else if (inc_press) begin
                        player_choice <= (player_choice == MAX_CHOICE) ? '0
                                       : player_choice + CW'(1);
                    end
                end
                ST_REVEAL: begin
                    res <= rev_res;
                    st  <= ST_SCORE;
                end
                ST_SCORE: begin
                    st <= ST_CHOOSE;
                    if (!clear_scores) begin
                        if (res == RES_WIN) begin
                            player_score <= p_inc;
                            if (p_inc == TARGET) begin
                                st         <= ST_OVER;
                                player_won <= 1'b1;
                            end
                        end else if (res == RES_LOSE) begin
                            cpu_score <= c_inc;
                            if (c_inc == TARGET) begin
                                st         <= ST_OVER;
                                player_won <= 1'b0;
                            end
                        end
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        st           <= ST_CHOOSE;
                        player_score <= '0;
                        cpu_score    <= '0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
            // Clear overrides any score update made above, in every state
            if (clear_scores) begin
                player_score <= '0;
                cpu_score    <= '0;
            end
        end
    end

`ifdef RPS_LED_SCROLL_EN
    logic [SCROLL_DIV_W-1:0] div;
    logic [9:0]              scroll;

    // Divider and pattern restart on every entry to OVER so the first step is a full period
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            div    <= '0;
            scroll <= 10'd1;
        end else if (st != ST_OVER) begin
            div    <= '0;
            scroll <= 10'd1;
        end else begin
            div <= div + 1'b1;
            if (&div) begin
                scroll <= {scroll[8:0], scroll[9]};
            end
        end
    end

    assign over_led = scroll;
`else
    localparam int div_w_unused = SCROLL_DIV_W;
    assign over_led = 10'h3FF;
`endif

    always_comb begin
        case (st)
            ST_IDLE:   led = LED_IDLE;
            ST_CHOOSE: led = LED_CHOOSE;
            ST_OVER:   led = player_won ? over_led : 10'h000;
            default:   led = 10'h000;
        endcase
    end

    assign result     = res;
    assign state      = st;
    assign match_over = (st == ST_OVER);

endmodule
